// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and memory-port signal bundle for mem_port_arbiter
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 37
);
  logic              req0;
  logic              wr0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              gnt0;
  logic              rvalid0;

  logic              req1;
  logic              wr1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              gnt1;
  logic              rvalid1;

  logic [DATA_W-1:0] rdata;

  logic              mem_enable;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_write_data;
  logic [DATA_W-1:0] mem_read_data;

  modport slave (
    input  req0, wr0, addr0, wdata0,
    input  req1, wr1, addr1, wdata1,
    input  mem_read_data,
    output gnt0, rvalid0, gnt1, rvalid1, rdata,
    output mem_enable, mem_wr_en, mem_addr, mem_write_data
  );

  modport master (
    output req0, wr0, addr0, wdata0,
    output req1, wr1, addr1, wdata1,
    output mem_read_data,
    input  gnt0, rvalid0, gnt1, rvalid1, rdata,
    input  mem_enable, mem_wr_en, mem_addr, mem_write_data
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester arbiter for a single-port table SRAM
// Requester 0 has priority; requester 1 is promoted after MAX_WAIT consecutive lost cycles.
module mem_port_arbiter #(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 37,
  parameter int RD_LATENCY = 1,
  parameter int MAX_WAIT   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_port_arbiter_if.slave   bus
);

  localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam int TAG_D  = RD_LATENCY + 1;

  logic [WAIT_W-1:0] r_wait_cnt;
  logic              w_override;
  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_grant;
  logic              w_sel_wr;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;

  logic              r_mem_enable;
  logic              r_mem_wr_en;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_write_data;

  // Index 0 is the newest tag; the oldest stage lines up with mem_read_data.
  logic [TAG_D-1:0]  r_tag_vld;
  logic [TAG_D-1:0]  r_tag_id;

  assign w_override = (MAX_WAIT > 0) && (r_wait_cnt == WAIT_W'(MAX_WAIT));

  // Grants are masked during reset so every output reads zero while rst_n is low.
  assign w_gnt0 = rst_n & bus.req0 & ~(bus.req1 & w_override);
  assign w_gnt1 = rst_n & bus.req1 & (~bus.req0 | w_override);

  always_comb begin
    w_grant     = w_gnt0 | w_gnt1;
    w_sel_wr    = bus.wr0;
    w_sel_addr  = bus.addr0;
    w_sel_wdata = bus.wdata0;
    if (w_gnt1) begin
      w_sel_wr    = bus.wr1;
      w_sel_addr  = bus.addr1;
      w_sel_wdata = bus.wdata1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
    end else if (!bus.req1 || w_gnt1) begin
      r_wait_cnt <= '0;
    end else if (r_wait_cnt != WAIT_W'(MAX_WAIT)) begin
      r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_enable     <= 1'b0;
      r_mem_wr_en      <= 1'b0;
      r_mem_addr       <= '0;
      r_mem_write_data <= '0;
    end else begin
      r_mem_enable <= w_grant;
      r_mem_wr_en  <= w_grant & w_sel_wr;
      if (w_grant) begin
        r_mem_addr       <= w_sel_addr;
        r_mem_write_data <= w_sel_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag_vld <= '0;
      r_tag_id  <= '0;
    end else begin
      r_tag_vld <= {r_tag_vld[TAG_D-2:0], w_grant & ~w_sel_wr};
      r_tag_id  <= {r_tag_id[TAG_D-2:0], w_gnt1};
    end
  end

  assign bus.gnt0           = w_gnt0;
  assign bus.gnt1           = w_gnt1;
  assign bus.rvalid0        = r_tag_vld[TAG_D-1] & ~r_tag_id[TAG_D-1];
  assign bus.rvalid1        = r_tag_vld[TAG_D-1] &  r_tag_id[TAG_D-1];
  assign bus.rdata          = bus.mem_read_data;
  assign bus.mem_enable     = r_mem_enable;
  assign bus.mem_wr_en      = r_mem_wr_en;
  assign bus.mem_addr       = r_mem_addr;
  assign bus.mem_write_data = r_mem_write_data;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  localparam int AW = 5;
  localparam int DW = 37;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ia ();
  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ib ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(1), .MAX_WAIT(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ia)
  );
  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(3), .MAX_WAIT(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ib)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  function automatic logic [DW-1:0] init_val(int i);
    return 37'h0A_0000_0000 + DW'(i);
  endfunction

  // Synchronous SRAM models: latency 1 for instance a, latency 3 for instance b.
  logic [DW-1:0] mem_a [32];
  logic [DW-1:0] mem_b [32];
  logic [DW-1:0] dl_a;
  logic [DW-1:0] dl_b [3];
  logic          init_done = 1'b0;

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 32; i++) begin
        mem_a[i] <= init_val(i);
        mem_b[i] <= init_val(i);
      end
      init_done <= 1'b1;
    end else begin
      if (ia.mem_enable && ia.mem_wr_en) mem_a[ia.mem_addr] <= ia.mem_write_data;
      if (ib.mem_enable && ib.mem_wr_en) mem_b[ib.mem_addr] <= ib.mem_write_data;
    end
    dl_a    <= (ia.mem_enable && !ia.mem_wr_en) ? mem_a[ia.mem_addr] : '0;
    dl_b[0] <= (ib.mem_enable && !ib.mem_wr_en) ? mem_b[ib.mem_addr] : '0;
    dl_b[1] <= dl_b[0];
    dl_b[2] <= dl_b[1];
  end

  assign ia.mem_read_data = dl_a;
  assign ib.mem_read_data = dl_b[2];

  typedef struct {
    logic          rst, req0, wr0, req1, wr1;
    logic [AW-1:0] addr0, addr1, maddr;
    logic [DW-1:0] wdata0, wdata1, rdata, mwd;
    logic          gnt0, gnt1, rv0, rv1, men, mwr;
  } sample_t;

  // Behavioural model: shadow table, last command, returns scheduled by cycle.
  bit            minit = 1'b0;
  int            mcyc  = 0;
  int            lost      [2];
  bit            pend_en   [2];
  bit            pend_wr   [2];
  logic [AW-1:0] last_addr [2];
  logic [DW-1:0] last_data [2];
  logic [DW-1:0] shadow    [2][32];
  bit            ret_v     [2][8];
  bit            ret_id    [2][8];
  logic [DW-1:0] ret_d     [2][8];

  task automatic model_check(int k, int lat, int mw, sample_t s);
    string         p;
    int            slot;
    int            ds;
    bit            g0, g1, w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    p    = (k == 0) ? "a" : "b";
    slot = mcyc % 8;
    if (!s.rst) begin
      chk({p, "_rst_gnt0"}, s.gnt0, 0);
      chk({p, "_rst_gnt1"}, s.gnt1, 0);
      chk({p, "_rst_rv0"}, s.rv0, 0);
      chk({p, "_rst_rv1"}, s.rv1, 0);
      chk({p, "_rst_men"}, s.men, 0);
      chk({p, "_rst_mwr"}, s.mwr, 0);
      chk({p, "_rst_maddr"}, s.maddr, 0);
      chk({p, "_rst_mwd"}, s.mwd, 0);
      lost[k] = 0; pend_en[k] = 0; pend_wr[k] = 0;
      last_addr[k] = '0; last_data[k] = '0;
      for (int i = 0; i < 8; i++) ret_v[k][i] = 0;
      return;
    end
    g0 = s.req0 && !(s.req1 && mw > 0 && lost[k] >= mw);
    g1 = s.req1 && !g0;
    chk($sformatf("%s_gnt0_c%0d", p, mcyc), s.gnt0, g0);
    chk($sformatf("%s_gnt1_c%0d", p, mcyc), s.gnt1, g1);
    chk($sformatf("%s_men_c%0d", p, mcyc), s.men, pend_en[k]);
    chk($sformatf("%s_mwr_c%0d", p, mcyc), s.mwr, pend_en[k] && pend_wr[k]);
    chk($sformatf("%s_maddr_c%0d", p, mcyc), s.maddr, last_addr[k]);
    chk($sformatf("%s_mwd_c%0d", p, mcyc), s.mwd, last_data[k]);
    chk($sformatf("%s_rv0_c%0d", p, mcyc), s.rv0, ret_v[k][slot] && !ret_id[k][slot]);
    chk($sformatf("%s_rv1_c%0d", p, mcyc), s.rv1, ret_v[k][slot] && ret_id[k][slot]);
    if (ret_v[k][slot]) chk($sformatf("%s_rdata_c%0d", p, mcyc), s.rdata, ret_d[k][slot]);
    ret_v[k][slot] = 0;

    lost[k]    = (s.req1 && !g1) ? lost[k] + 1 : 0;
    pend_en[k] = g0 || g1;
    pend_wr[k] = 0;
    if (g0 || g1) begin
      w = g1 ? s.wr1 : s.wr0;
      a = g1 ? s.addr1 : s.addr0;
      d = g1 ? s.wdata1 : s.wdata0;
      last_addr[k] = a;
      last_data[k] = d;
      pend_wr[k]   = w;
      if (w) begin
        shadow[k][a] = d;
      end else begin
        ds = (mcyc + 1 + lat) % 8;
        ret_v[k][ds]  = 1;
        ret_id[k][ds] = g1;
        ret_d[k][ds]  = shadow[k][a];
      end
    end
  endtask

  always @(negedge clk) begin
    sample_t sa, sb;
    if (!minit) begin
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < 32; i++) shadow[k][i] = 37'h0A_0000_0000 + DW'(i);
      minit = 1'b1;
    end
    sa.rst = rst_n; sa.req0 = ia.req0; sa.wr0 = ia.wr0; sa.addr0 = ia.addr0; sa.wdata0 = ia.wdata0;
    sa.req1 = ia.req1; sa.wr1 = ia.wr1; sa.addr1 = ia.addr1; sa.wdata1 = ia.wdata1;
    sa.gnt0 = ia.gnt0; sa.gnt1 = ia.gnt1; sa.rv0 = ia.rvalid0; sa.rv1 = ia.rvalid1; sa.rdata = ia.rdata;
    sa.men = ia.mem_enable; sa.mwr = ia.mem_wr_en; sa.maddr = ia.mem_addr; sa.mwd = ia.mem_write_data;
    sb.rst = rst_n; sb.req0 = ib.req0; sb.wr0 = ib.wr0; sb.addr0 = ib.addr0; sb.wdata0 = ib.wdata0;
    sb.req1 = ib.req1; sb.wr1 = ib.wr1; sb.addr1 = ib.addr1; sb.wdata1 = ib.wdata1;
    sb.gnt0 = ib.gnt0; sb.gnt1 = ib.gnt1; sb.rv0 = ib.rvalid0; sb.rv1 = ib.rvalid1; sb.rdata = ib.rdata;
    sb.men = ib.mem_enable; sb.mwr = ib.mem_wr_en; sb.maddr = ib.mem_addr; sb.mwd = ib.mem_write_data;
    model_check(0, 1, 4, sa);
    model_check(1, 3, 0, sb);
    mcyc++;
  end

  task automatic drv(int k, int port, logic req, logic wr, logic [AW-1:0] addr, logic [DW-1:0] wd);
    if (k == 0 && port == 0) begin ia.req0 = req; ia.wr0 = wr; ia.addr0 = addr; ia.wdata0 = wd; end
    if (k == 0 && port == 1) begin ia.req1 = req; ia.wr1 = wr; ia.addr1 = addr; ia.wdata1 = wd; end
    if (k == 1 && port == 0) begin ib.req0 = req; ib.wr0 = wr; ib.addr0 = addr; ib.wdata0 = wd; end
    if (k == 1 && port == 1) begin ib.req1 = req; ib.wr1 = wr; ib.addr1 = addr; ib.wdata1 = wd; end
  endtask

  task automatic cyc_start();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 2; k++)
      for (int p = 0; p < 2; p++) drv(k, p, 0, 0, '0, '0);
    repeat (3) @(posedge clk);
    at_neg();
    chk("lit_rst_gnt0", ia.gnt0, 0);
    chk("lit_rst_men", ia.mem_enable, 0);
    chk("lit_rst_rv1", ib.rvalid1, 0);
    cyc_start(); rst_n = 1'b1;
    cyc_start();

    // Single read from requester 0
    cyc_start(); drv(0, 0, 1, 0, 5, '0); at_neg();
    chk("t1_gnt0", ia.gnt0, 1); chk("t1_gnt1", ia.gnt1, 0);
    cyc_start(); drv(0, 0, 0, 0, 5, '0); at_neg();
    chk("t1_men", ia.mem_enable, 1); chk("t1_maddr", ia.mem_addr, 5);
    cyc_start(); at_neg();
    chk("t1_rv0", ia.rvalid0, 1); chk("t1_rv1", ia.rvalid1, 0);
    chk("t1_rdata", ia.rdata, 37'h0A_0000_0005);
    cyc_start();

    // Write then read-back on requester 1
    cyc_start(); drv(0, 1, 1, 1, 3, 37'h1_2345_6789); at_neg();
    chk("t2_gnt1_w", ia.gnt1, 1);
    cyc_start(); drv(0, 1, 1, 0, 3, 37'h1_2345_6789); at_neg();
    chk("t2_gnt1_r", ia.gnt1, 1); chk("t2_mwr", ia.mem_wr_en, 1);
    chk("t2_mwd", ia.mem_write_data, 37'h1_2345_6789);
    cyc_start(); drv(0, 1, 0, 0, 3, '0); at_neg();
    chk("t2_men", ia.mem_enable, 1); chk("t2_mwr_rd", ia.mem_wr_en, 0);
    cyc_start(); at_neg();
    chk("t2_rv1", ia.rvalid1, 1); chk("t2_rdata", ia.rdata, 37'h1_2345_6789);
    cyc_start();

    // Starvation override with MAX_WAIT=4
    for (int c = 0; c < 10; c++) begin
      cyc_start(); drv(0, 0, 1, 0, 7, '0); drv(0, 1, 1, 0, 9, '0); at_neg();
      chk($sformatf("t3_gnt1_c%0d", c), ia.gnt1, (c == 4 || c == 9));
      chk($sformatf("t3_gnt0_c%0d", c), ia.gnt0, !(c == 4 || c == 9));
    end
    cyc_start(); drv(0, 0, 0, 0, '0, '0); drv(0, 1, 0, 0, '0, '0);
    repeat (3) cyc_start();

    // Strict priority with MAX_WAIT=0
    for (int c = 0; c < 20; c++) begin
      cyc_start(); drv(1, 0, 1, 0, 1, '0); drv(1, 1, 1, 0, 2, '0); at_neg();
      chk($sformatf("t4_gnt1_c%0d", c), ib.gnt1, 0);
    end
    cyc_start(); drv(1, 0, 0, 0, '0, '0); at_neg();
    chk("t4_gnt1_release", ib.gnt1, 1);
    cyc_start(); drv(1, 1, 0, 0, '0, '0);
    repeat (6) cyc_start();

    // Latency sweep with RD_LATENCY=3, alternating requesters
    cyc_start(); drv(1, 0, 1, 0, 2, '0);
    cyc_start(); drv(1, 0, 0, 0, '0, '0); drv(1, 1, 1, 0, 12, '0);
    cyc_start(); drv(1, 1, 0, 0, '0, '0); drv(1, 0, 1, 0, 4, '0);
    cyc_start(); drv(1, 0, 0, 0, '0, '0); drv(1, 1, 1, 0, 14, '0);
    cyc_start(); drv(1, 1, 0, 0, '0, '0); at_neg();
    chk("t5_rv0_c4", ib.rvalid0, 1); chk("t5_rd_c4", ib.rdata, 37'h0A_0000_0002);
    cyc_start(); at_neg();
    chk("t5_rv1_c5", ib.rvalid1, 1); chk("t5_rd_c5", ib.rdata, 37'h0A_0000_000C);
    cyc_start(); at_neg();
    chk("t5_rv0_c6", ib.rvalid0, 1); chk("t5_rd_c6", ib.rdata, 37'h0A_0000_0004);
    cyc_start(); at_neg();
    chk("t5_rv1_c7", ib.rvalid1, 1); chk("t5_rd_c7", ib.rdata, 37'h0A_0000_000E);
    cyc_start();

    // Reset while a read is in flight
    cyc_start(); drv(0, 0, 1, 0, 6, '0); at_neg();
    chk("t6_gnt0", ia.gnt0, 1);
    cyc_start(); rst_n = 1'b0; at_neg();
    chk("t6_rst_gnt0", ia.gnt0, 0); chk("t6_rst_men", ia.mem_enable, 0);
    chk("t6_rst_maddr", ia.mem_addr, 0);
    cyc_start(); rst_n = 1'b1; drv(0, 0, 0, 0, '0, '0); at_neg();
    chk("t6_no_rv_c2", ia.rvalid0, 0);
    cyc_start(); at_neg();
    chk("t6_no_rv_c3", ia.rvalid0, 0);
    cyc_start(); drv(0, 0, 1, 0, 8, '0); at_neg();
    chk("t6_regrant", ia.gnt0, 1);
    cyc_start(); drv(0, 0, 0, 0, '0, '0); at_neg();
    chk("t6_men", ia.mem_enable, 1); chk("t6_maddr", ia.mem_addr, 8);
    cyc_start(); at_neg();
    chk("t6_rv0", ia.rvalid0, 1); chk("t6_rdata", ia.rdata, 37'h0A_0000_0008);

    repeat (3) cyc_start();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port table SRAM between two requesters.
  - Requester 0: register-block table path (APB side).
  - Requester 1: hardware datapath engine.
- Arbitrates per cycle, registers the winning command onto the memory port, and routes returned read data back to the originator in order.
- Anti-starvation counter guarantees requester 1 progress under continuous register traffic.

Parameters:
- ADDR_W, 5, table address width.
- DATA_W, 37, table entry width.
- RD_LATENCY, 1, memory read latency in cycles from mem_enable to mem_read_data valid; legal 1..4.
- MAX_WAIT, 4, consecutive lost cycles before requester 1 overrides requester 0; 0 = strict priority, no override.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- req0  input  1  requester 0 command valid
- wr0  input  1  requester 0 write (1) / read (0)
- addr0  input  ADDR_W  requester 0 address
- wdata0  input  DATA_W  requester 0 write data
- gnt0  output  1  requester 0 command accepted this cycle
- rvalid0  output  1  requester 0 read data valid
- req1, wr1, addr1, wdata1, gnt1, rvalid1  as above for requester 1
- rdata  output  DATA_W  read data, shared; qualified by rvalid0/rvalid1
- mem_enable  output  1  memory access strobe
- mem_wr_en  output  1  memory write
- mem_addr  output  ADDR_W  memory address
- mem_write_data  output  DATA_W  memory write data
- mem_read_data  input  DATA_W  memory read data

Behaviour:
Clock and reset:
- One clock (clk); reset rst_n is asynchronous, active-low.
- Reset values: gnt0=gnt1=0, rvalid0=rvalid1=0, mem_enable=0, mem_wr_en=0, mem_addr=0, mem_write_data=0, wait counter=0, read-tag pipeline cleared.

Handshake:
- reqN/wrN/addrN/wdataN must stay stable until gnt.
- Transfer occurs when reqN & gntN in the same cycle.
- gntN is combinational from reqN and the wait counter.
- At most one grant per cycle; gntN never asserts without reqN.

Arbitration, cycle N:
- Only one req high: it wins.
- Both high: requester 0 wins, unless MAX_WAIT>0 and wait counter == MAX_WAIT, in which case requester 1 wins.
- Wait counter update:
  - Increments when req1 & !gnt1; saturates at MAX_WAIT.
  - Clears when gnt1, or when req1 is low.

Memory command:
- The granted command is registered and driven on cycle N+1: mem_enable=1, mem_wr_en=wr, mem_addr, mem_write_data.
- No grant in cycle N: mem_enable=0 and mem_wr_en=0 at N+1; addr/data hold their last value.
- Back-to-back grants give mem_enable high on consecutive cycles (full throughput).

Read return:
- A read tag (valid + requester id) is shifted through a (1+RD_LATENCY)-deep pipeline.
- rvalidN asserts exactly 1+RD_LATENCY cycles after the granting cycle, for one cycle.
- rdata = mem_read_data (combinational pass-through).
- Returns are in grant order; interleaved requesters return interleaved.
- Writes produce no rvalid.

Ordering and hazards:
- Single in-order memory port, so read-after-write to the same address returns the new data when the write was granted earlier.
- No forwarding required.

Reset mid-operation:
- In-flight reads are discarded: no rvalid after reset deasserts.
- Pending writes not yet driven are dropped.

Test Plan:
- Single read: req0=1, wr0=0, addr0=5 at cycle 0, RD_LATENCY=1 -> gnt0 at cycle 0; mem_enable=1, mem_addr=5 at cycle 1; rvalid0=1 with rdata = mem content at cycle 2; rvalid1 stays 0.
- Write then read: req1 writes addr 3 = 37'h1_2345_6789 (granted cycle 0), then reads addr 3 (granted cycle 1) -> mem_wr_en=1 at cycle 1, mem_enable read at cycle 2, rvalid1 at cycle 3 with rdata=37'h1_2345_6789.
- Starvation, MAX_WAIT=4: req0 and req1 held high continuously -> gnt0 on cycles 0-3, gnt1 on cycle 4, counter cleared, gnt0 on cycles 5-8, gnt1 on cycle 9.
- Strict priority, MAX_WAIT=0: both requesting for 20 cycles -> gnt1 never asserts; drop req0 -> gnt1 the same cycle.
- Latency sweep, RD_LATENCY=3: alternating reads 0,1,0,1 granted on cycles 0-3 -> rvalid0 on cycles 4 and 6, rvalid1 on cycles 5 and 7, each with the matching address data.
- Reset mid-flight: read granted on cycle 0, rst_n low at cycle 1 -> all outputs zero immediately; no rvalid after release; the next request is granted normally.
